sap1_control_sequencer: RTL

Control sequencer for the SAP-1 CPU core: a six-state ring counter (T1–T6) plus an instruction decoder that turns the IR opcode nibble into the per-cycle control word.
- Drives the bus enables and load strobes of the PC, MAR, RAM, IR, A, B, ALU and output register.
- Sits between the IR and the datapath inside the CPU top level.
- Halts the machine on HLT until reset.

---
 rtl/sap1_control_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: one-hot T1..T6 ring counter, HALT trap and control-word decoder.
// Optional JMP/JZ instructions are compiled in when the SAP1_JMP_EN macro is defined.
module sap1_control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       out_load,
    output logic [5:0] tstate,
    output logic       halted
);

    typedef enum logic [5:0] {
        ST_HALT = 6'b000000,
        ST_T1   = 6'b000001,
        ST_T2   = 6'b000010,
        ST_T3   = 6'b000100,
        ST_T4   = 6'b001000,
        ST_T5   = 6'b010000,
        ST_T6   = 6'b100000
    } state_e;

`ifdef SAP1_JMP_EN
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_JZ  = 4'h4;
`else
    logic unused_zero_flag_s;
    assign unused_zero_flag_s = zero_flag;
`endif

    state_e state_q, state_d;
    logic   halted_q, halted_d;

    // Next state: advance on enabled edges, trap into HALT when T4 sees HLT
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (ena && !halted_q) begin
            case (state_q)
                ST_T1: state_d = ST_T2;
                ST_T2: state_d = ST_T3;
                ST_T3: state_d = ST_T4;
                ST_T4: begin
                    if (opcode == OP_HLT) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = ST_T5;
                    end
                end
                ST_T5: state_d = ST_T6;
                ST_T6: state_d = ST_T1;
                default: state_d = ST_T1;
            endcase
        end else begin
            state_d  = state_q;
            halted_d = halted_q;
        end
    end

    // State and halt registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign tstate = state_q;
    assign halted = halted_q;

    // Control decode; rst_n gating keeps T1 strobes quiet while reset is held
    always_comb begin
        pc_inc   = 1'b0;
        pc_out   = 1'b0;
        pc_load  = 1'b0;
        mar_load = 1'b0;
        ram_out  = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        alu_sub  = 1'b0;
        alu_out  = 1'b0;
        out_load = 1'b0;
        if (ena && rst_n && !halted_q) begin
            case (state_q)
                ST_T1: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                ST_T2: pc_inc = 1'b1;
                ST_T3: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                end
                ST_T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_out   = 1'b1;
                            mar_load = 1'b1;
                        end
                        OP_OUT: begin
                            a_out    = 1'b1;
                            out_load = 1'b1;
                        end
`ifdef SAP1_JMP_EN
                        OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_load = 1'b1;
                        end
                        OP_JZ: begin
                            ir_out  = zero_flag;
                            pc_load = zero_flag;
                        end
`endif
                        default: ;
                    endcase
                end
                ST_T5: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_load  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_load  = 1'b1;
                            alu_sub = (opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                ST_T6: begin
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            alu_out = 1'b1;
                            a_load  = 1'b1;
                            alu_sub = (opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end else begin
            pc_inc = 1'b0;
        end
    end

endmodule
